// File: rtl/vector_load_unit.sv
// vector_load_unit: reads vecSize elements from byte memory into a shadow buffer and commits them atomically to vect_out.
// Latency: start to done is vecSize+2 cycles, so one vector completes every vecSize+3 cycles.
// Backpressure: none; start is ignored while busy. Defining VLOAD_STRIDE_EN adds the stride port; without it lanes are contiguous.
module vector_load_unit #(
    parameter int regSize   = 8,
    parameter int vecSize   = 16,
    parameter int addrWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addrWidth-1:0] base_addr,
`ifdef VLOAD_STRIDE_EN
    input  logic [addrWidth-1:0] stride,
`endif
    output logic                 mem_rd_en,
    output logic [addrWidth-1:0] mem_addr,
    input  logic [regSize-1:0]   mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic [regSize-1:0]   vect_out [vecSize-1:0]
);
    localparam int CW = (vecSize > 1) ? $clog2(vecSize) : 1;
    localparam logic [CW-1:0] LAST = CW'(vecSize - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        issue_cnt;
    logic [CW-1:0]        cap_cnt;
    logic                 rd_en_d;
    logic [addrWidth-1:0] addr_step;
    logic [regSize-1:0]   shadow [vecSize-1:0];

`ifdef VLOAD_STRIDE_EN
    logic [addrWidth-1:0] stride_q;
    assign addr_step = stride_q;
`else
    assign addr_step = addrWidth'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (issue_cnt == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Addresses accumulate by the step, so lane i lands on base + i*step modulo 2^addrWidth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            done      <= 1'b0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            rd_en_d   <= 1'b0;
`ifdef VLOAD_STRIDE_EN
            stride_q  <= '0;
`endif
            for (int k = 0; k < vecSize; k++) begin
                shadow[k]   <= '0;
                vect_out[k] <= '0;
            end
        end else begin
            done    <= 1'b0;
            rd_en_d <= mem_rd_en;
            if (rd_en_d) begin
                shadow[cap_cnt] <= mem_rdata;
                cap_cnt         <= cap_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= base_addr;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
`ifdef VLOAD_STRIDE_EN
                        stride_q  <= stride;
`endif
                    end
                end
                READ: begin
                    if (issue_cnt == LAST) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                        mem_addr  <= mem_addr + addr_step;
                    end
                end
                DRAIN: begin
                    // The final lane arrives this cycle; merge it so the commit is whole.
                    for (int k = 0; k < vecSize; k++)
                        vect_out[k] <= (rd_en_d && (CW'(k) == cap_cnt)) ? mem_rdata : shadow[k];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_load_unit.sv
// Bench for vector_load_unit: randomized memory contents checked against an arithmetic lane-address model.
module tb_vector_load_unit;
    localparam int RS = 8;
    localparam int VS = 16;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
`ifdef VLOAD_STRIDE_EN
    logic [AW-1:0] stride = '0;
`endif
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [RS-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic [RS-1:0] vect_out [VS-1:0];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [AW-1:0] addr_log[$];
    logic [RS-1:0] mem [0:65535];
    logic [RS-1:0] exp_vec [VS-1:0];

    vector_load_unit #(.regSize(RS), .vecSize(VS), .addrWidth(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
`ifdef VLOAD_STRIDE_EN
        .stride(stride),
`endif
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .vect_out(vect_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
            addr_log.push_back(mem_addr);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int i);
        int a;
        a = (int'(b) + i * int'(s)) % 65536;
        return a[AW-1:0];
    endfunction

    // Caller sits at a negedge; start is driven there and the task returns at the negedge after done.
    task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] strd, input bit busy_start);
        logic [RS-1:0] nv [VS-1:0];
        int done_cyc;
        int dc0;
        int bad;
        for (int i = 0; i < VS; i++) nv[i] = mem[lane_addr(base, strd, i)];
        addr_log.delete();
        dc0 = done_cnt;
        done_cyc = -1;
        base_addr = base;
`ifdef VLOAD_STRIDE_EN
        stride = strd;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            start = 1'b0;
            if (busy_start && cyc == 5) begin
                start = 1'b1;
                base_addr = 16'h0200;
            end
            if (cyc == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin n_err++; $display("FAIL busy_c1 got %b want 1", busy); end
            end
            if (cyc == VS + 1) begin
                n_cmp++;
                if (mem_rd_en !== 1'b0 || busy !== 1'b1) begin
                    n_err++; $display("FAIL drain_state rd_en=%b busy=%b want rd_en=0 busy=1", mem_rd_en, busy);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                bad = -1;
                for (int k = 0; k < VS; k++) if (vect_out[k] !== exp_vec[k]) bad = k;
                n_cmp++;
                if (bad >= 0) begin
                    n_err++; $display("FAIL atomic cyc %0d lane %0d got %h want %h", cyc, bad, vect_out[bad], exp_vec[bad]);
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        n_cmp++;
        if (done_cyc != VS + 2) begin n_err++; $display("FAIL done_cycle got %0d want %0d", done_cyc, VS + 2); end
        for (int k = 0; k < VS; k++) begin
            n_cmp++;
            if (vect_out[k] !== nv[k]) begin
                n_err++; $display("FAIL lane%0d base %h got %h want %h", k, base, vect_out[k], nv[k]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL post_done busy=%b done=%b want 0 0", busy, done); end
        n_cmp++;
        if (done_cnt - dc0 != 1) begin n_err++; $display("FAIL done_count got %0d want 1", done_cnt - dc0); end
        n_cmp++;
        if (addr_log.size() != VS) begin
            n_err++; $display("FAIL addr_count got %0d want %0d", addr_log.size(), VS);
        end else begin
            for (int i = 0; i < VS; i++) begin
                n_cmp++;
                if (addr_log[i] !== lane_addr(base, strd, i)) begin
                    n_err++; $display("FAIL addr%0d got %h want %h", i, addr_log[i], lane_addr(base, strd, i));
                end
            end
        end
        for (int k = 0; k < VS; k++) exp_vec[k] = nv[k];
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || done !== 1'b0 || mem_addr !== '0) begin
            n_err++; $display("FAIL reset_ctrl busy=%b rd=%b done=%b addr=%h want 0", busy, mem_rd_en, done, mem_addr);
        end
        for (int k = 0; k < VS; k++) begin
            n_cmp++;
            if (vect_out[k] !== '0) begin n_err++; $display("FAIL reset_lane%0d got %h want 00", k, vect_out[k]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_contiguous();
        for (int i = 0; i < VS; i++) mem[16'h0100 + i] = RS'(i * 8'h11);
        do_load(16'h0100, 16'h0001, 1'b0);
        n_cmp++;
        if (vect_out[0] !== 8'h00 || vect_out[15] !== 8'hFF) begin
            n_err++; $display("FAIL contig_ends got %h/%h want 00/ff", vect_out[0], vect_out[15]);
        end
    endtask

    task automatic test_wrap();
        do_load(16'hFFFC, 16'h0001, 1'b0);
    endtask

    task automatic test_start_while_busy();
        do_load(16'h0100, 16'h0001, 1'b0);
        do_load(16'h0100, 16'h0001, 1'b1);
    endtask

    task automatic test_reset_midload();
        int dc0;
        start = 1'b1;
        base_addr = 16'(($urandom % 65536));
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midreset_ctrl busy=%b rd=%b done=%b want 0", busy, mem_rd_en, done);
        end
        for (int k = 0; k < VS; k++) begin
            n_cmp++;
            if (vect_out[k] !== '0) begin n_err++; $display("FAIL midreset_lane%0d got %h want 00", k, vect_out[k]); end
            exp_vec[k] = '0;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        n_cmp++;
        if (done_cnt != dc0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midreset_nodone dones=%0d busy=%b want 0 0", done_cnt - dc0, busy);
        end
        do_load(16'(($urandom % 65536)), 16'h0001, 1'b0);
    endtask

    task automatic test_back_to_back();
        repeat (4) do_load(16'(($urandom % 65536)), 16'h0001, 1'b0);
    endtask

`ifdef VLOAD_STRIDE_EN
    task automatic test_stride();
        do_load(16'h0010, 16'h0004, 1'b0);
        do_load(16'(($urandom % 65536)), 16'h0000, 1'b0);
        do_load(16'(($urandom % 65536)), 16'(($urandom % 65536)), 1'b0);
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = RS'($urandom);
        for (int k = 0; k < VS; k++) exp_vec[k] = '0;
        test_reset();
        test_contiguous();
        test_wrap();
        test_start_while_busy();
        test_reset_midload();
        test_back_to_back();
`ifdef VLOAD_STRIDE_EN
        test_stride();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
